// File: rtl/counter_poll_pkg.sv
// Shared definitions for the counter poll master slice.
// - state_t    : read-master FSM states (IDLE/AR/R/OUT)
// - RESP_*     : AXI read response codes of interest
// - DATA_W     : width of the counter slave's read data bus
package counter_poll_pkg;

    localparam int unsigned DATA_W = 64;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/counter_poll_master_period_tick_gen.sv
// Periodic trigger source.
// Ports:
//   clk         - clock
//   rst         - synchronous active-high reset
//   period_en   - enables the timer
//   period      - cycles between ticks; 0 disables the timer
//   period_tick - one-cycle pulse every 'period' cycles while enabled
module period_tick_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        period_en,
    input  logic [31:0] period,
    output logic        period_tick
);

    logic [31:0] cnt;
    logic        active;
    logic        at_end;

    assign active = period_en && (period != '0);
    // '>=' rather than '==' so that shrinking 'period' below the current
    // count reloads immediately instead of running through a 32-bit wrap.
    assign at_end      = (cnt >= (period - 32'd1));
    assign period_tick = active && at_end;

    always_ff @(posedge clk) begin
        if (rst || !active) begin
            cnt <= '0;
        end else if (at_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 32'd1;
        end
    end

endmodule

// File: rtl/counter_poll_master.sv
// AXI-lite read master that samples a 64-bit cycle counter slave.
// One read is issued per trigger (software pulse or period timer); each
// result is delivered with the delta from the previous sample on a
// valid/ready stream.
// Ports:
//   m_axi_aclk, m_axi_areset       - clock, synchronous active-high reset
//   trig, period_en, period        - trigger sources
//   m_axi_ar*, m_axi_r*            - AXI-lite read channels to counter slave
//   smp_valid/ready, smp_cnt,
//   smp_delta, smp_first           - sample output stream
//   err_resp, err_timeout          - sticky error flags
//   drop_cnt                       - saturating dropped-trigger count
module counter_poll_master
    import counter_poll_pkg::*;
#(
    parameter logic [11:0] CNT_ADDR = 12'h000,
    parameter int unsigned TIMEOUT  = 1024,
    parameter int unsigned DROP_W   = 16
) (
    input  logic              m_axi_aclk,
    input  logic              m_axi_areset,
    input  logic              trig,
    input  logic              period_en,
    input  logic [31:0]       period,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    output logic [11:0]       m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    output logic              smp_valid,
    input  logic              smp_ready,
    output logic [DATA_W-1:0] smp_cnt,
    output logic [DATA_W-1:0] smp_delta,
    output logic              smp_first,
    output logic              err_resp,
    output logic              err_timeout,
    output logic [DROP_W-1:0] drop_cnt
);

    localparam int unsigned WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t              state;
    state_t              state_nxt;
    logic                period_tick;
    logic                tev;
    logic                pending;
    logic                have_prev;
    logic [DATA_W-1:0]   prev;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                out_done;

    period_tick_gen u_period (
        .clk         (m_axi_aclk),
        .rst         (m_axi_areset),
        .period_en   (period_en),
        .period      (period),
        .period_tick (period_tick)
    );

    assign tev          = trig || period_tick;
    assign out_done     = (state == ST_OUT) && smp_ready;
    assign m_axi_araddr = CNT_ADDR;
    assign m_axi_arprot = '0;

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        smp_valid     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tev || pending) state_nxt = ST_AR;
            end
            ST_AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_nxt = ST_R;
            end
            ST_R: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) state_nxt = ST_OUT;
            end
            ST_OUT: begin
                smp_valid = 1'b1;
                if (smp_ready) state_nxt = (pending || tev) ? ST_AR : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Trigger bookkeeping: one read in flight plus one pending.
    // When OUT hands off while both pending and a new tev exist, one of
    // them launches the next read and the other stays pending.
    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            pending  <= 1'b0;
            drop_cnt <= '0;
        end else if (state == ST_IDLE) begin
            pending <= 1'b0;
        end else if (out_done) begin
            pending <= pending && tev;
        end else if (tev) begin
            if (!pending) begin
                pending <= 1'b1;
            end else if (drop_cnt != '1) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge m_axi_aclk) begin
        if (m_axi_areset) begin
            smp_cnt     <= '0;
            smp_delta   <= '0;
            smp_first   <= 1'b0;
            prev        <= '0;
            have_prev   <= 1'b0;
            err_resp    <= 1'b0;
            err_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            if (state == ST_AR && m_axi_arready) begin
                wait_cnt <= '0;
            end
            if (state == ST_R) begin
                if (m_axi_rvalid) begin
                    smp_cnt   <= m_axi_rdata;
                    smp_delta <= have_prev ? (m_axi_rdata - prev) : '0;
                    smp_first <= !have_prev;
                    prev      <= m_axi_rdata;
                    have_prev <= 1'b1;
                    if (m_axi_rresp != RESP_OKAY) err_resp <= 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    err_timeout <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_counter_poll_master.sv
module tb_counter_poll_master;
    import counter_poll_pkg::*;

    localparam logic [11:0] ADDR = 12'h0A8;

    logic        clk;
    logic        areset;
    logic        trig;
    logic        period_en;
    logic [31:0] period;
    logic        arvalid;
    logic        arready;
    logic [11:0] araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        smp_valid;
    logic        smp_ready;
    logic [63:0] smp_cnt;
    logic [63:0] smp_delta;
    logic        smp_first;
    logic        err_resp;
    logic        err_timeout;
    logic [15:0] drop_cnt;

    logic        rvalid_en;
    logic [63:0] rd_data;
    logic [1:0]  rd_resp;

    int checks = 0;
    int errors = 0;
    int unsigned cyc = 0;
    int unsigned ar_times[$];

    counter_poll_master #(
        .CNT_ADDR (ADDR),
        .TIMEOUT  (1024),
        .DROP_W   (16)
    ) dut (
        .m_axi_aclk    (clk),
        .m_axi_areset  (areset),
        .trig          (trig),
        .period_en     (period_en),
        .period        (period),
        .m_axi_arvalid (arvalid),
        .m_axi_arready (arready),
        .m_axi_araddr  (araddr),
        .m_axi_arprot  (arprot),
        .m_axi_rvalid  (rvalid),
        .m_axi_rready  (rready),
        .m_axi_rdata   (rdata),
        .m_axi_rresp   (rresp),
        .smp_valid     (smp_valid),
        .smp_ready     (smp_ready),
        .smp_cnt       (smp_cnt),
        .smp_delta     (smp_delta),
        .smp_first     (smp_first),
        .err_resp      (err_resp),
        .err_timeout   (err_timeout),
        .drop_cnt      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Zero-latency slave: arready always high, rvalid under bench control.
    assign arready = 1'b1;
    assign rvalid  = rvalid_en;
    assign rdata   = rd_data;
    assign rresp   = rd_resp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // AR handshake monitor, sampled mid-cycle before the handshake edge.
    always @(negedge clk) begin
        if (arvalid && arready) begin
            ar_times.push_back(cyc);
            check("araddr", 64'(araddr), 64'(ADDR));
        end
    end

    task automatic do_sample(input logic [63:0] d, input logic [1:0] resp, output int lat);
        rd_data   = d;
        rd_resp   = resp;
        rvalid_en = 1'b1;
        trig      = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        lat  = 1;
        while (!smp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic accept();
        smp_ready = 1'b1;
        @(negedge clk);
        smp_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " arvalid"},     64'(arvalid),     64'd0);
        check({tag, " rready"},      64'(rready),      64'd0);
        check({tag, " smp_valid"},   64'(smp_valid),   64'd0);
        check({tag, " smp_cnt"},     smp_cnt,          64'd0);
        check({tag, " smp_delta"},   smp_delta,        64'd0);
        check({tag, " smp_first"},   64'(smp_first),   64'd0);
        check({tag, " err_resp"},    64'(err_resp),    64'd0);
        check({tag, " err_timeout"}, 64'(err_timeout), 64'd0);
        check({tag, " drop_cnt"},    64'(drop_cnt),    64'd0);
    endtask

    typedef struct {
        logic [63:0] rdata;
        logic [63:0] exp_cnt;
        logic [63:0] exp_delta;
        logic        exp_first;
    } vec_t;

    vec_t vec[5];

    initial begin
        int lat;
        int n0;

        vec[0] = '{rdata: 64'd100,                  exp_cnt: 64'd100,                  exp_delta: 64'd0,                  exp_first: 1'b1};
        vec[1] = '{rdata: 64'd250,                  exp_cnt: 64'd250,                  exp_delta: 64'd150,                exp_first: 1'b0};
        vec[2] = '{rdata: 64'd1000,                 exp_cnt: 64'd1000,                 exp_delta: 64'd750,                exp_first: 1'b0};
        vec[3] = '{rdata: 64'hFFFF_FFFF_FFFF_FFFE,  exp_cnt: 64'hFFFF_FFFF_FFFF_FFFE,  exp_delta: 64'hFFFF_FFFF_FFFF_FC16, exp_first: 1'b0};
        vec[4] = '{rdata: 64'd1,                    exp_cnt: 64'd1,                    exp_delta: 64'd3,                  exp_first: 1'b0};

        areset    = 1'b1;
        trig      = 1'b0;
        period_en = 1'b0;
        period    = '0;
        smp_ready = 1'b0;
        rvalid_en = 1'b0;
        rd_data   = '0;
        rd_resp   = RESP_OKAY;
        repeat (3) @(negedge clk);
        areset = 1'b0;
        check_all_zero("reset");
        check("arprot", 64'(arprot), 64'd0);
        repeat (2) @(negedge clk);

        // Table-driven samples, including the modular wrap of the delta.
        for (int i = 0; i < 5; i++) begin
            n0 = ar_times.size();
            do_sample(vec[i].rdata, RESP_OKAY, lat);
            check($sformatf("v%0d latency", i), 64'(lat), 64'd3);
            check($sformatf("v%0d smp_cnt", i), smp_cnt, vec[i].exp_cnt);
            check($sformatf("v%0d smp_delta", i), smp_delta, vec[i].exp_delta);
            check($sformatf("v%0d smp_first", i), 64'(smp_first), 64'(vec[i].exp_first));
            check($sformatf("v%0d ar_count", i), 64'(ar_times.size() - n0), 64'd1);
            check($sformatf("v%0d err_resp", i), 64'(err_resp), 64'd0);
            accept();
            check($sformatf("v%0d idle", i), 64'(smp_valid), 64'd0);
        end

        // Periodic trigger every 8 cycles, then period=0 stops it.
        smp_ready = 1'b1;
        rd_data   = 64'd5000;
        period    = 32'd8;
        period_en = 1'b1;
        repeat (4) @(negedge clk);
        ar_times.delete();
        repeat (64) @(negedge clk);
        check("period ar_count", 64'(ar_times.size()), 64'd8);
        for (int i = 1; i < ar_times.size(); i++) begin
            check($sformatf("period interval%0d", i), 64'(ar_times[i] - ar_times[i-1]), 64'd8);
        end
        period = '0;
        repeat (6) @(negedge clk);
        ar_times.delete();
        repeat (40) @(negedge clk);
        check("period0 ar_count", 64'(ar_times.size()), 64'd0);
        period_en = 1'b0;
        smp_ready = 1'b0;
        @(negedge clk);

        // Triggers during OUT: one pends, two are dropped.
        do_sample(64'd6000, RESP_OKAY, lat);
        check("drop latency", 64'(lat), 64'd3);
        for (int k = 0; k < 3; k++) begin
            trig = 1'b1;
            @(negedge clk);
            trig = 1'b0;
            @(negedge clk);
        end
        check("drop_cnt", 64'(drop_cnt), 64'd2);
        check("drop held valid", 64'(smp_valid), 64'd1);
        check("drop held cnt", smp_cnt, 64'd6000);
        n0 = ar_times.size();
        rd_data   = 64'd6100;
        smp_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("pending ar_count", 64'(ar_times.size() - n0), 64'd1);
        check("pending idle arvalid", 64'(arvalid), 64'd0);
        check("pending idle valid", 64'(smp_valid), 64'd0);
        check("pending cnt", smp_cnt, 64'd6100);
        smp_ready = 1'b0;

        // Withheld rvalid: timeout flag at R cycle 1024, then error response.
        rvalid_en = 1'b0;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        @(negedge clk);
        check("to rready", 64'(rready), 64'd1);
        repeat (1023) @(negedge clk);
        check("to before", 64'(err_timeout), 64'd0);
        @(negedge clk);
        check("to after", 64'(err_timeout), 64'd1);
        repeat (75) @(negedge clk);
        check("to still waiting", 64'(rready), 64'd1);
        rd_data   = 64'd777;
        rd_resp   = RESP_SLVERR;
        rvalid_en = 1'b1;
        lat = 0;
        while (!smp_valid && lat < 5) begin
            @(negedge clk);
            lat++;
        end
        check("slverr latency", 64'(lat), 64'd1);
        check("slverr cnt", smp_cnt, 64'd777);
        check("slverr delta", smp_delta, 64'd777 - 64'd6100);
        check("err_resp", 64'(err_resp), 64'd1);
        check("err_timeout sticky", 64'(err_timeout), 64'd1);
        accept();
        rd_resp = RESP_OKAY;
        check("err_resp sticky", 64'(err_resp), 64'd1);

        // Reset while in R, late rvalid ignored, then a fresh first sample.
        rvalid_en = 1'b0;
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        @(negedge clk);
        check("mid rready", 64'(rready), 64'd1);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        check_all_zero("midreset");
        rd_data   = 64'd999;
        rvalid_en = 1'b1;
        repeat (3) @(negedge clk);
        check("late rvalid valid", 64'(smp_valid), 64'd0);
        check("late rvalid rready", 64'(rready), 64'd0);
        do_sample(64'd42, RESP_OKAY, lat);
        check("post latency", 64'(lat), 64'd3);
        check("post cnt", smp_cnt, 64'd42);
        check("post delta", smp_delta, 64'd0);
        check("post first", 64'(smp_first), 64'd1);
        accept();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_poll_master.md
Name: counter_poll_master

Overview:
- AXI-lite read master that samples the 64-bit cycle counter slave over its 12-bit-address / 64-bit-data read channel.
- Issues one read per trigger, either a software pulse or an internal period timer.
- Delivers each sample plus the delta from the previous sample on a valid/ready stream to the host-side stats logic.
- Sits directly upstream of the counter slave on the same AXI-lite segment. Single clock domain.

Parameters:
- CNT_ADDR, 12'h000: araddr driven for every counter read.
- TIMEOUT, 1024: cycles waiting in R before the sticky timeout flag sets; must be >= 1.
- DROP_W, 16: width of the saturating dropped-trigger counter.

Ports:
- m_axi_aclk  in  1  sole clock.
- m_axi_areset  in  1  synchronous, active-high reset.
- trig  in  1  single-cycle sample request.
- period_en  in  1  enables the periodic trigger.
- period  in  32  cycles between periodic triggers; 0 = periodic off.
- m_axi_arvalid  out  1  read address valid.
- m_axi_arready  in  1  read address ready.
- m_axi_araddr  out  12  always CNT_ADDR.
- m_axi_arprot  out  3  always 3'b000.
- m_axi_rvalid  in  1  read data valid.
- m_axi_rready  out  1  read data ready.
- m_axi_rdata  in  64  counter value.
- m_axi_rresp  in  2  read response.
- smp_valid  out  1  sample available.
- smp_ready  in  1  consumer accepts sample.
- smp_cnt  out  64  sampled counter value.
- smp_delta  out  64  smp_cnt minus previous sample, modulo 2^64.
- smp_first  out  1  first sample since reset.
- err_resp  out  1  sticky; set when rresp != 0.
- err_timeout  out  1  sticky; set when a read waits TIMEOUT cycles.
- drop_cnt  out  DROP_W  saturating count of dropped triggers.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, pending=0, have_prev=0, prev=0, period timer=0.
- Trigger event tev = trig OR period_tick. Coincident trig and period_tick count as one event.
- Period timer:
  - Counts only while period_en=1 and period!=0.
  - Asserts period_tick for one cycle when the count reaches period-1, then reloads to 0.
  - Deasserting period_en or writing period=0 clears the timer the next cycle.
- FSM states IDLE, AR, R, OUT:
  - IDLE: on tev or pending -> AR; clear pending in the same cycle.
  - AR: arvalid=1, araddr=CNT_ADDR. arvalid stays high until arready; never withdrawn. AR -> R on the arready cycle.
  - R: rready=1. On rvalid: capture rdata into smp_cnt; smp_delta = have_prev ? rdata-prev : 0; smp_first = !have_prev; prev<=rdata; have_prev<=1; set err_resp if rresp!=0. Data is still delivered on error. -> OUT.
  - OUT: smp_valid=1 with data held stable until smp_ready. On the smp_ready cycle -> IDLE, or -> AR directly if pending is set or tev occurs that cycle.
- Latency: tev in IDLE -> arvalid the next cycle. With arready and rvalid both asserted the cycle they are sampled, smp_valid rises 3 cycles after tev.
- tev while not in IDLE:
  - If pending=0: pending<=1.
  - Otherwise: drop_cnt+=1, saturating at all-ones.
  - Depth is one outstanding plus one pending.
- Timeout: R-state wait counter resets on R entry and sets err_timeout at TIMEOUT cycles. The transaction is never abandoned; the FSM keeps waiting for rvalid.
- Sticky flags clear only on reset.
- Delta wrap: rdata < prev yields the 64-bit modular difference (e.g. prev=FFFF_FFFF_FFFF_FFFE, rdata=1 -> delta=3).
- Reset mid-transaction: all state returns to reset values next cycle. A late rvalid arriving after reset is ignored in IDLE (rready=0).

Decomposition:
- Shared package counter_poll_pkg holds: FSM state enum (IDLE/AR/R/OUT), AXI resp constants (OKAY=0, SLVERR=2), the 64-bit data-width constant.
- One natural sub-module: period_tick_gen (period timer producing period_tick).
- The rest stays flat in counter_poll_master.

Test Plan:
- Reset, then trig at cycle 5; slave arready/rvalid immediate, rdata=100 -> one AR at addr CNT_ADDR; smp_valid with cnt=100, delta=0, first=1.
- Second trig with rdata=250 -> cnt=250, delta=150, first=0.
- period_en=1, period=8, smp_ready=1, zero-latency slave -> arvalid rises every 8 cycles exactly; period=0 -> no further AR.
- Hold smp_ready=0, pulse trig 3 times during OUT -> pending set, drop_cnt=2; release smp_ready -> exactly one more read, then IDLE.
- rvalid withheld 1100 cycles with TIMEOUT=1024 -> err_timeout=1 at cycle 1024 of R; later rvalid with rresp=2 -> sample delivered, err_resp=1.
- prev=FFFF_FFFF_FFFF_FFFE, next rdata=1 -> delta=3. Assert m_axi_areset while in R -> all outputs 0, next read gives first=1, delta=0.
